// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter sharing one 32-bit ripple adder among NREQ
// requesters. Each accepted request runs IDLE -> CALC -> RESP, so grants are
// at least three cycles apart.
// Optional feature: define ADD_ARBITER_OVF_EN to add the rsp_ovf output
// (two's-complement signed overflow of the registered sum).
//
// state | meaning
// IDLE  | searching for a requester from ptr upward, grant drives req_ready
// CALC  | latched operands feed the adder, result registered at the edge
// RESP  | result held until rsp_valid && rsp_ready

module add_arbiter_ripple32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  // Carry ripples bit by bit from a carry-in of zero.
  always_comb begin
    logic c;
    c     = 1'b0;
    sum_o = '0;
    for (int i = 0; i < 32; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

module add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_carry,
  output logic [IDW-1:0]       rsp_id
`ifdef ADD_ARBITER_OVF_EN
  ,
  output logic                 rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [31:0]    op_a_q, op_a_d;
  logic [31:0]    op_b_q, op_b_d;
  logic [IDW-1:0] op_id_q, op_id_d;

  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_sum_q, rsp_sum_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
`ifdef ADD_ARBITER_OVF_EN
  logic           rsp_ovf_q, rsp_ovf_d;
`endif

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [31:0]    grant_a, grant_b;
  logic [31:0]    add_sum;
  logic           add_carry;

  add_arbiter_ripple32 u_adder (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .sum_o  (add_sum),
    .cout_o (add_carry)
  );

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = cand[IDW-1:0];
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Select the granted requester's operands from the packed buses.
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_a = req_a[32*i +: 32];
        grant_b = req_b[32*i +: 32];
      end
    end
  end

  // Next-state, operand latch, result register and accept-strobe logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_id_d    = rsp_id_q;
`ifdef ADD_ARBITER_OVF_EN
    rsp_ovf_d   = rsp_ovf_q;
`endif
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          op_a_d  = grant_a;
          op_b_d  = grant_b;
          op_id_d = grant_idx;
          ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        rsp_sum_d   = add_sum;
        rsp_carry_d = add_carry;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
`ifdef ADD_ARBITER_OVF_EN
        rsp_ovf_d   = (op_a_q[31] == op_b_q[31]) && (add_sum[31] != op_a_q[31]);
`endif
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant must never be visible while reset is being applied.
    if (!rst_n) req_ready = '0;
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
`ifdef ADD_ARBITER_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_id_q    <= rsp_id_d;
`ifdef ADD_ARBITER_OVF_EN
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;
`ifdef ADD_ARBITER_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule
